// File: rtl/jtag_bb_pkg.sv
// Shared definitions for the JTAG bit-bang master: register map, CTRL fields,
// shifter state encoding and the byte-enable helper.
package jtag_bb_pkg;

  localparam logic [2:0] OFF_CTRL = 3'd0;
  localparam logic [2:0] OFF_DIV  = 3'd1;
  localparam logic [2:0] OFF_TMS  = 3'd2;
  localparam logic [2:0] OFF_TDI  = 3'd3;
  localparam logic [2:0] OFF_TDO  = 3'd4;

  localparam int unsigned CTRL_LEN_LSB = 0;
  localparam int unsigned CTRL_LEN_W   = 6;
  localparam int unsigned CTRL_START   = 8;
  localparam int unsigned CTRL_TRST    = 9;
  localparam int unsigned CTRL_DONE    = 10;
  localparam int unsigned CTRL_BUSY    = 31;

  typedef enum logic [1:0] {
    StIdle,
    StLow,
    StHigh
  } shift_state_e;

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/jtag_bitbang_master_if.sv
// Request/grant bus used by software to reach the JTAG bit-bang registers.
interface jtag_bitbang_master_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/jtag_bb_shifter.sv
// TCK generator and shift engine: drives TMS/TDI per bit, captures TDO on each
// rising TCK edge and pulses done after the final falling edge.
module jtag_bb_shifter
  import jtag_bb_pkg::*;
#(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [5:0]       len_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [31:0]      tms_vec_i,
  input  logic [31:0]      tdi_vec_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [31:0]      tdo_vec_o,
  output logic             jtag_tck_o,
  output logic             jtag_tms_o,
  output logic             jtag_tdi_o,
  input  logic             jtag_tdo_i
);

  shift_state_e     state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [4:0]       n_q, n_d;
  logic [31:0]      tms_sh_q, tms_sh_d;
  logic [31:0]      tdi_sh_q, tdi_sh_d;
  logic [31:0]      tdo_q, tdo_d;
  logic             tck_q, tck_d;
  logic             tms_q, tms_d;
  logic             tdi_q, tdi_d;
  logic             done_q, done_d;

  // LEN of 0 wraps to 31 here, giving a 32-bit shift.
  logic [5:0] len_m1;
  logic [4:0] last_n;
  logic       div_hit;
  logic       unused_len;

  assign len_m1     = len_i - 6'd1;
  assign last_n     = len_m1[4:0];
  assign unused_len = len_m1[5];
  assign div_hit    = (cnt_q == div_i);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    tms_sh_d = tms_sh_q;
    tdi_sh_d = tdi_sh_q;
    tdo_d    = tdo_q;
    tck_d    = tck_q;
    tms_d    = tms_q;
    tdi_d    = tdi_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d  = StLow;
          tms_sh_d = tms_vec_i;
          tdi_sh_d = tdi_vec_i;
          tdo_d    = '0;
          n_d      = '0;
          cnt_d    = '0;
          tck_d    = 1'b0;
          tms_d    = tms_vec_i[0];
          tdi_d    = tdi_vec_i[0];
        end
      end
      StLow: begin
        if (div_hit) begin
          state_d      = StHigh;
          cnt_d        = '0;
          tck_d        = 1'b1;
          tdo_d[n_q]   = jtag_tdo_i;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      StHigh: begin
        if (div_hit) begin
          cnt_d = '0;
          tck_d = 1'b0;
          if (n_q == last_n) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StLow;
            n_d     = n_q + 5'd1;
            tms_d   = tms_sh_q[n_d];
            tdi_d   = tdi_sh_q[n_d];
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      n_q      <= '0;
      tms_sh_q <= '0;
      tdi_sh_q <= '0;
      tdo_q    <= '0;
      tck_q    <= 1'b0;
      tms_q    <= 1'b1;
      tdi_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      tms_sh_q <= tms_sh_d;
      tdi_sh_q <= tdi_sh_d;
      tdo_q    <= tdo_d;
      tck_q    <= tck_d;
      tms_q    <= tms_d;
      tdi_q    <= tdi_d;
      done_q   <= done_d;
    end
  end

  assign busy_o     = (state_q != StIdle);
  assign done_o     = done_q;
  assign tdo_vec_o  = tdo_q;
  assign jtag_tck_o = tck_q;
  assign jtag_tms_o = tms_q;
  assign jtag_tdi_o = tdi_q;

endmodule

// File: rtl/jtag_bitbang_master.sv
// Memory-mapped JTAG host: bus decode and register file around the shifter.
module jtag_bitbang_master
  import jtag_bb_pkg::*;
#(
  parameter int unsigned      DIV_W     = 16,
  parameter logic [DIV_W-1:0] RESET_DIV = DIV_W'(3)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  jtag_bitbang_master_if.slave  bus,
  output logic                  jtag_tck_o,
  output logic                  jtag_tms_o,
  output logic                  jtag_tdi_o,
  output logic                  jtag_trst_no,
  input  logic                  jtag_tdo_i,
  output logic                  done_o
);

  logic [5:0]       len_q, len_d;
  logic             trst_q, trst_d;
  logic             done_flag_q, done_flag_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [31:0]      tms_q, tms_d;
  logic [31:0]      tdi_q, tdi_d;
  logic             rvalid_q;
  logic [31:0]      rdata_q, rdata_d;

  logic        busy;
  logic        shift_done;
  logic [31:0] tdo_vec;
  logic        start;
  logic [2:0]  word;
  logic        wr, rd, wr_ctrl;
  logic [31:0] mask;
  logic [31:0] ctrl_rd;
  logic        unused_addr;

  assign word        = bus.addr[4:2];
  assign wr          = bus.req & bus.we;
  assign rd          = bus.req & ~bus.we;
  assign wr_ctrl     = wr & (word == OFF_CTRL);
  assign mask        = be_mask(bus.be);
  assign unused_addr = ^{bus.addr[31:5], bus.addr[1:0]};

  assign start = wr_ctrl & bus.be[1] & bus.wdata[CTRL_START] & ~busy;

  always_comb begin
    ctrl_rd                                      = '0;
    ctrl_rd[CTRL_LEN_LSB +: CTRL_LEN_W]          = len_q;
    ctrl_rd[CTRL_TRST]                           = trst_q;
    ctrl_rd[CTRL_DONE]                           = done_flag_q;
    ctrl_rd[CTRL_BUSY]                           = busy;
  end

  always_comb begin
    len_d       = len_q;
    trst_d      = trst_q;
    done_flag_d = done_flag_q;
    div_d       = div_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    rdata_d     = '0;

    if (wr_ctrl && bus.be[0] && !busy) len_d = bus.wdata[CTRL_LEN_LSB +: CTRL_LEN_W];
    if (wr_ctrl && bus.be[1]) begin
      trst_d = bus.wdata[CTRL_TRST];
      if (bus.wdata[CTRL_DONE]) done_flag_d = 1'b0;
    end
    // A completion in the same cycle as a clear must leave DONE set.
    if (shift_done) done_flag_d = 1'b1;

    if (wr && !busy) begin
      case (word)
        OFF_DIV: div_d = DIV_W'((32'(div_q) & ~mask) | (bus.wdata & mask));
        OFF_TMS: tms_d = (tms_q & ~mask) | (bus.wdata & mask);
        OFF_TDI: tdi_d = (tdi_q & ~mask) | (bus.wdata & mask);
        default: ;
      endcase
    end

    if (rd) begin
      case (word)
        OFF_CTRL: rdata_d = ctrl_rd;
        OFF_DIV:  rdata_d = 32'(div_q);
        OFF_TMS:  rdata_d = tms_q;
        OFF_TDI:  rdata_d = tdi_q;
        OFF_TDO:  rdata_d = tdo_vec;
        default:  rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      len_q       <= '0;
      trst_q      <= 1'b0;
      done_flag_q <= 1'b0;
      div_q       <= RESET_DIV;
      tms_q       <= '0;
      tdi_q       <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      len_q       <= len_d;
      trst_q      <= trst_d;
      done_flag_q <= done_flag_d;
      div_q       <= div_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      rvalid_q    <= bus.req;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.gnt    = bus.req;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign jtag_trst_no = ~trst_q;
  assign done_o       = shift_done;

  jtag_bb_shifter #(
    .DIV_W (DIV_W)
  ) u_shifter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start),
    .len_i      (len_q),
    .div_i      (div_q),
    .tms_vec_i  (tms_q),
    .tdi_vec_i  (tdi_q),
    .busy_o     (busy),
    .done_o     (shift_done),
    .tdo_vec_o  (tdo_vec),
    .jtag_tck_o (jtag_tck_o),
    .jtag_tms_o (jtag_tms_o),
    .jtag_tdi_o (jtag_tdi_o),
    .jtag_tdo_i (jtag_tdo_i)
  );

endmodule

// File: tb/tb_jtag_bitbang_master.sv
// Directed bench for jtag_bitbang_master with TDO looped back from TDI.
module tb_jtag_bitbang_master;

  logic clk_i;
  logic rst_i;
  logic jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_trst_no, jtag_tdo_i, done_o;

  jtag_bitbang_master_if bus_if ();

  jtag_bitbang_master dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .bus          (bus_if),
    .jtag_tck_o   (jtag_tck_o),
    .jtag_tms_o   (jtag_tms_o),
    .jtag_tdi_o   (jtag_tdi_o),
    .jtag_trst_no (jtag_trst_no),
    .jtag_tdo_i   (jtag_tdo_i),
    .done_o       (done_o)
  );

  assign jtag_tdo_i = jtag_tdi_o;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  int          rise_cnt = 0;
  int          hi_cnt   = 0;
  int          done_cnt = 0;
  int          busy_cnt = 0;
  logic        tck_prev = 1'b0;
  logic [31:0] tms_at_rise = '0;

  always @(negedge clk_i) begin
    if (jtag_tck_o && !tck_prev) begin
      rise_cnt    = rise_cnt + 1;
      tms_at_rise = {jtag_tms_o, tms_at_rise[31:1]};
    end
    tck_prev = jtag_tck_o;
    if (jtag_tck_o) hi_cnt = hi_cnt + 1;
    if (done_o)     done_cnt = done_cnt + 1;
    if (dut.busy)   busy_cnt = busy_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(posedge clk_i); #1;
    bus_if.req = 1'b1; bus_if.we = 1'b1; bus_if.addr = a; bus_if.wdata = d; bus_if.be = be;
    @(posedge clk_i); #1;
    bus_if.req = 1'b0; bus_if.we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(posedge clk_i); #1;
    bus_if.req = 1'b1; bus_if.we = 1'b0; bus_if.addr = a; bus_if.be = 4'h0;
    @(posedge clk_i); #1;
    bus_if.req = 1'b0;
    d = bus_if.rdata;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_i);
      if (!dut.busy) break;
    end
    check(tag, {31'd0, dut.busy}, 32'd0);
    repeat (3) @(negedge clk_i);
  endtask

  int r0, h0, d0, b0;
  task automatic snap();
    r0 = rise_cnt; h0 = hi_cnt; d0 = done_cnt; b0 = busy_cnt;
  endtask

  logic [31:0] rd;

  initial begin
    rst_i = 1'b1;
    bus_if.req = 1'b0; bus_if.we = 1'b0; bus_if.addr = '0; bus_if.be = '0; bus_if.wdata = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Reset state
    check("rst_tck", {31'd0, jtag_tck_o}, 32'd0);
    check("rst_tms", {31'd0, jtag_tms_o}, 32'd1);
    check("rst_trst_n", {31'd0, jtag_trst_no}, 32'd1);
    check("rst_done_o", {31'd0, done_o}, 32'd0);
    check("rst_rvalid", {31'd0, bus_if.rvalid}, 32'd0);
    bus_read(32'h00, rd); check("rst_ctrl", rd, 32'h0);
    check("rvalid_after_req", {31'd0, bus_if.rvalid}, 32'd1);
    bus_read(32'h04, rd); check("rst_div", rd, 32'd3);

    // Loopback: DIV=0, LEN=8, TDI=0xA5
    bus_write(32'h04, 32'd0, 4'hF);
    bus_write(32'h0C, 32'h0000_00A5, 4'hF);
    snap();
    bus_write(32'h00, 32'h0000_0108, 4'hF);
    wait_idle("lb_idle");
    bus_read(32'h10, rd); check("lb_tdo", rd, 32'h0000_00A5);
    check("lb_rises", rise_cnt - r0, 8);
    check("lb_busy_cycles", busy_cnt - b0, 16);
    check("lb_done_pulses", done_cnt - d0, 1);
    bus_read(32'h00, rd); check("lb_ctrl_done", rd, 32'h0000_0408);

    // Busy protection: DIV=1, LEN=4, TDI=1; retarget TDI and restart mid-shift
    bus_write(32'h04, 32'd1, 4'hF);
    bus_write(32'h0C, 32'h1, 4'hF);
    snap();
    bus_write(32'h00, 32'h0000_0104, 4'hF);
    bus_write(32'h0C, 32'hF, 4'hF);
    bus_write(32'h00, 32'h0000_0104, 4'hF);
    wait_idle("bp_idle");
    bus_read(32'h0C, rd); check("bp_tdi_kept", rd, 32'h1);
    bus_read(32'h10, rd); check("bp_tdo", rd, 32'h1);
    check("bp_rises", rise_cnt - r0, 4);
    check("bp_busy_cycles", busy_cnt - b0, 16);
    check("bp_done_pulses", done_cnt - d0, 1);

    // Timing: DIV=3, LEN=0 (32 bits), TMS=0x1F
    bus_write(32'h04, 32'd3, 4'hF);
    bus_write(32'h08, 32'h0000_001F, 4'hF);
    snap();
    bus_write(32'h00, 32'h0000_0100, 4'hF);
    wait_idle("tm_idle");
    check("tm_rises", rise_cnt - r0, 32);
    check("tm_busy_cycles", busy_cnt - b0, 256);
    check("tm_tck_high_cycles", hi_cnt - h0, 128);
    check("tm_tms_at_rise", tms_at_rise, 32'h0000_001F);
    check("tm_tms_hold", {31'd0, jtag_tms_o}, 32'd0);
    check("tm_done_pulses", done_cnt - d0, 1);

    // Byte enables: only byte 0 of DIV updates
    bus_write(32'h04, 32'h0000_1205, 4'h1);
    bus_read(32'h04, rd); check("be_div", rd, 32'h0000_0005);
    bus_read(32'h14, rd); check("unmapped_read", rd, 32'h0);

    // TRST and DONE clear
    bus_write(32'h00, 32'h0000_0200, 4'h2);
    check("trst_asserted", {31'd0, jtag_trst_no}, 32'd0);
    bus_write(32'h00, 32'h0000_0600, 4'h2);
    bus_read(32'h00, rd); check("done_cleared", rd & 32'h0000_0600, 32'h0000_0200);
    bus_write(32'h00, 32'h0000_0000, 4'h2);
    check("trst_released", {31'd0, jtag_trst_no}, 32'd1);

    // Reset mid-shift: DIV=0, LEN=8, TDI=0xFF, reset after 3 rising edges
    bus_write(32'h04, 32'd0, 4'hF);
    bus_write(32'h0C, 32'hFF, 4'hF);
    snap();
    bus_write(32'h00, 32'h0000_0108, 4'hF);
    for (int i = 0; i < 200; i++) begin
      if (rise_cnt - r0 >= 3) break;
      @(negedge clk_i);
    end
    check("mr_reached_bit3", rise_cnt - r0, 3);
    @(posedge clk_i); #1 rst_i = 1'b1;
    @(posedge clk_i); #1;
    check("mr_busy", {31'd0, dut.busy}, 32'd0);
    check("mr_tck", {31'd0, jtag_tck_o}, 32'd0);
    check("mr_tms", {31'd0, jtag_tms_o}, 32'd1);
    rst_i = 1'b0;
    repeat (4) @(negedge clk_i);
    check("mr_no_done", done_cnt - d0, 0);
    bus_read(32'h10, rd); check("mr_tdo", rd, 32'h0);
    bus_read(32'h00, rd); check("mr_ctrl", rd, 32'h0);
    bus_read(32'h04, rd); check("mr_div", rd, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
